// File: rtl/peripheral_access_master.sv
// Command-driven burst master for the crossing bridge slave port: issues write/read
// bursts of up to 16 word transfers and returns read results with an end-of-command marker.
module peripheral_access_master #(
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic        slave_clk,
   input  logic        slave_reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [3:0]  cmd_addr,
   input  logic [4:0]  cmd_len,
   input  logic [3:0]  cmd_byteenable,
   input  logic        wdata_valid,
   input  logic [31:0] wdata,
   output logic        wdata_ready,
   output logic        rdata_valid,
   output logic [31:0] rdata,
   output logic        rdata_eop,
   output logic        done,
   output logic        err_unexpected,
   output logic [3:0]  av_address,
   output logic [3:0]  av_nativeaddress,
   output logic [3:0]  av_byteenable,
   output logic        av_read,
   output logic        av_write,
   output logic [31:0] av_writedata,
   input  logic        av_waitrequest,
   input  logic [31:0] av_readdata,
   input  logic        av_readdatavalid,
   input  logic        av_endofpacket
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

   state_t      state, state_next;
   logic        ready_en;
   logic        wr_q;
   logic [3:0]  addr_q;
   logic [3:0]  be_q;
   logic [4:0]  remain_q;
   logic [4:0]  resp_left_q;
   logic [3:0]  outstanding;
   logic        read_hold;
   logic        done_next;
   logic        cmd_acc;
   logic        xfer_acc;
   logic        rd_acc;
   logic        rdv_ok;
   logic        last_acc;
   logic [4:0]  len_eff;
   logic        unused_eop;

   assign unused_eop = av_endofpacket;

   assign len_eff  = ((cmd_len == 5'd0) || (cmd_len > 5'd16)) ? 5'd16 : cmd_len;

   // ready_en keeps cmd_ready low while reset is held and until the first edge after release
   assign cmd_ready = ready_en && (state == IDLE);
   assign cmd_acc   = cmd_valid && cmd_ready;

   assign av_write  = (state == ISSUE) && wr_q && wdata_valid;
   assign av_read   = (state == ISSUE) && !wr_q && ((outstanding < MAX_OUT) || read_hold);

   assign av_address       = addr_q;
   assign av_nativeaddress = addr_q;
   assign av_byteenable    = be_q;
   assign av_writedata     = av_write ? wdata : 32'd0;

   assign xfer_acc    = (av_read || av_write) && !av_waitrequest;
   assign rd_acc      = av_read && !av_waitrequest;
   assign wdata_ready = av_write && !av_waitrequest;
   assign last_acc    = xfer_acc && (remain_q == 5'd1);

   // A strobe with nothing in flight is dropped rather than counted
   assign rdv_ok      = av_readdatavalid && (outstanding != 4'd0);

   always_ff @(posedge slave_clk or negedge slave_reset_n) begin
      if (!slave_reset_n) begin
         state    <= IDLE;
         ready_en <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         ready_en <= 1'b1;
         done     <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_acc) state_next = ISSUE;
         end
         ISSUE: begin
            if (last_acc) begin
               if (wr_q) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            // last result is on rdata this cycle when both reach zero
            if ((outstanding == 4'd0) && (resp_left_q == 5'd0)) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge slave_clk or negedge slave_reset_n) begin
      if (!slave_reset_n) begin
         wr_q     <= 1'b0;
         addr_q   <= 4'd0;
         be_q     <= 4'd0;
         remain_q <= 5'd0;
      end else if (cmd_acc) begin
         wr_q     <= cmd_write;
         addr_q   <= cmd_addr;
         be_q     <= cmd_byteenable;
         remain_q <= len_eff;
      end else if (xfer_acc) begin
         addr_q   <= addr_q + 4'd1;
         remain_q <= remain_q - 5'd1;
      end
   end

   always_ff @(posedge slave_clk or negedge slave_reset_n) begin
      if (!slave_reset_n) begin
         outstanding <= 4'd0;
         read_hold   <= 1'b0;
         resp_left_q <= 5'd0;
      end else begin
         outstanding <= outstanding + {3'd0, rd_acc} - {3'd0, rdv_ok};
         read_hold   <= av_read && av_waitrequest;
         if (cmd_acc) begin
            resp_left_q <= cmd_write ? 5'd0 : len_eff;
         end else if (rdv_ok) begin
            resp_left_q <= resp_left_q - 5'd1;
         end
      end
   end

   // Read result stage: one register between the bridge strobe and the client
   always_ff @(posedge slave_clk or negedge slave_reset_n) begin
      if (!slave_reset_n) begin
         rdata_valid    <= 1'b0;
         rdata_eop      <= 1'b0;
         rdata          <= 32'd0;
         err_unexpected <= 1'b0;
      end else begin
         rdata_valid <= rdv_ok;
         rdata_eop   <= rdv_ok && (resp_left_q == 5'd1);
         if (rdv_ok) rdata <= av_readdata;
         if (av_readdatavalid && (outstanding == 4'd0)) err_unexpected <= 1'b1;
      end
   end

endmodule

// File: tb/tb_peripheral_access_master.sv
// Bench for peripheral_access_master: table of burst commands run against a bridge-slave
// model with a read-result scoreboard, plus hand sequences for error and reset corners.
module tb_peripheral_access_master;

   localparam int MAXO = 8;

   logic        slave_clk = 1'b0;
   logic        slave_reset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [3:0]  cmd_addr, cmd_byteenable;
   logic [4:0]  cmd_len;
   logic        wdata_valid, wdata_ready;
   logic [31:0] wdata;
   logic        rdata_valid, rdata_eop, done, err_unexpected;
   logic [31:0] rdata;
   logic [3:0]  av_address, av_nativeaddress, av_byteenable;
   logic        av_read, av_write, av_waitrequest, av_readdatavalid, av_endofpacket;
   logic [31:0] av_writedata, av_readdata;

   peripheral_access_master #(.MAX_OUTSTANDING(MAXO)) dut (
      .slave_clk(slave_clk), .slave_reset_n(slave_reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_byteenable(cmd_byteenable),
      .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
      .rdata_valid(rdata_valid), .rdata(rdata), .rdata_eop(rdata_eop),
      .done(done), .err_unexpected(err_unexpected),
      .av_address(av_address), .av_nativeaddress(av_nativeaddress),
      .av_byteenable(av_byteenable), .av_read(av_read), .av_write(av_write),
      .av_writedata(av_writedata), .av_waitrequest(av_waitrequest),
      .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
      .av_endofpacket(av_endofpacket)
   );

   always #5 slave_clk = ~slave_clk;

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [4:0]  len;
      logic [3:0]  be;
      int          n;        // effective transfer count
      int          wait_at;  // transfer index that sees waitrequest (-1 none)
      int          wait_n;   // waitrequest cycles on that transfer
      int          blk;      // readdatavalid withheld before this cycle
      int          acc_blk;  // transfers accepted by cycle blk-1
      logic        early;    // one response in the cycle a read is accepted with 3 in flight
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        eop;
   } rd_exp_t;

   vec_t        vecs[10];
   rd_exp_t     exp_q[$];
   logic [31:0] pend_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic        err_exp = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge slave_clk);
      #1;
   endtask

   function automatic logic [31:0] wdata_of(input int id, input int i);
      return 32'h0000_00A0 + 32'(i) + (32'(id) << 16);
   endfunction

   function automatic logic [31:0] rdata_of(input int id, input logic [3:0] a);
      return 32'hD000_0000 | (32'(id) << 8) | {28'd0, a};
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_av_read"}, av_read, 0);
      chk({tag, "_av_write"}, av_write, 0);
      chk({tag, "_wdata_ready"}, wdata_ready, 0);
      chk({tag, "_rdata_valid"}, rdata_valid, 0);
      chk({tag, "_rdata_eop"}, rdata_eop, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err_unexpected"}, err_unexpected, 0);
      chk({tag, "_av_address"}, av_address, 0);
      chk({tag, "_av_nativeaddress"}, av_nativeaddress, 0);
      chk({tag, "_av_byteenable"}, av_byteenable, 0);
      chk({tag, "_av_writedata"}, av_writedata, 0);
      chk({tag, "_rdata"}, rdata, 0);
   endtask

   // Runs one command; entered and left just after a rising edge.
   task automatic run_cmd(input vec_t v, input int id);
      int      acc = 0, act_acc = 0, resp = 0, cyc = 0, stalls = 0, outs_m = 0, stall_left;
      logic    cmd_taken = 0, done_due = 0, finished = 0, early_used = 0, hold = 0;
      logic    in_issue, rd_e, wr_e, give, done_next;
      logic [3:0] exp_addr;
      rd_exp_t e, pushed;
      stall_left = v.wait_n;
      while (!finished && cyc < 300) begin
         cmd_valid      = !cmd_taken;
         cmd_write      = v.wr;
         cmd_addr       = v.addr;
         cmd_len        = v.len;
         cmd_byteenable = v.be;
         wdata_valid    = v.wr;
         wdata          = wdata_of(id, acc);
         av_endofpacket = 1'b1;
         av_waitrequest = cmd_taken && (acc == v.wait_at) && (stall_left > 0);
         give = 1'b0;
         if (pend_q.size() > 0) begin
            if (v.early && !early_used && outs_m == 3) begin
               give = 1'b1;
               early_used = 1'b1;
            end else if (cyc >= v.blk) begin
               give = 1'b1;
            end
         end
         av_readdatavalid = give;
         av_readdata      = give ? pend_q.pop_front() : $urandom;
         if (give) begin
            pushed = '{av_readdata, (resp == v.n - 1)};
            resp++;
         end

         @(negedge slave_clk);
         in_issue  = cmd_taken && (acc < v.n);
         wr_e      = in_issue && v.wr;
         rd_e      = in_issue && !v.wr && ((outs_m < MAXO) || hold);
         exp_addr  = v.addr + 4'(acc);
         done_next = 1'b0;
         chk("done", done, done_due);
         chk("cmd_ready", cmd_ready, !cmd_taken || done_due);
         finished = done_due;
         chk("av_write", av_write, wr_e);
         chk("av_read", av_read, rd_e);
         chk("wdata_ready", wdata_ready, wr_e && !av_waitrequest);
         chk("err_unexpected", err_unexpected, err_exp);
         if (wr_e || rd_e) begin
            chk("av_address", av_address, exp_addr);
            chk("av_nativeaddress", av_nativeaddress, exp_addr);
            chk("av_byteenable", av_byteenable, v.be);
            if (wr_e) chk("av_writedata", av_writedata, wdata_of(id, acc));
            if (av_waitrequest) begin
               stall_left--;
               stalls++;
            end else begin
               if (rd_e) pend_q.push_back(rdata_of(id, exp_addr));
               acc++;
               if (wr_e && acc == v.n) done_next = 1'b1;
            end
         end
         if ((av_read || av_write) && !av_waitrequest) act_acc++;
         hold = rd_e && av_waitrequest;
         if (rd_e && !av_waitrequest) outs_m++;
         if (give) outs_m--;
         if (v.blk > 0 && cyc == v.blk - 1) begin
            chk("acc_at_block", act_acc, v.acc_blk);
            chk("av_read_blocked", av_read, 0);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rdata_valid", rdata_valid, 1);
            chk("rdata", rdata, e.data);
            chk("rdata_eop", rdata_eop, e.eop);
            if (e.eop) done_next = 1'b1;
         end else begin
            chk("rdata_valid_idle", rdata_valid, 0);
            chk("rdata_eop_idle", rdata_eop, 0);
         end
         if (give) exp_q.push_back(pushed);
         cmd_taken = 1'b1;
         done_due  = done_next;
         tick();
         cyc++;
      end
      cmd_valid = 1'b0;
      av_readdatavalid = 1'b0;
      av_waitrequest = 1'b0;
      if (!finished) begin
         n_chk++;
         n_fail++;
         $display("FAIL cmd_timeout: vector %0d still running after %0d cycles, expected done", id, cyc);
      end
      chk("xfer_count", act_acc, v.n);
      if (v.wait_at >= 0) chk("stall_cycles", stalls, v.wait_n);
   endtask

   initial begin
      vecs[0] = '{1'b1, 4'd14, 5'd4,  4'hF, 4,  -1, 0, 0,  0, 1'b0};
      vecs[1] = '{1'b1, 4'd2,  5'd3,  4'h3, 3,   1, 3, 0,  0, 1'b0};
      vecs[2] = '{1'b1, 4'd9,  5'd0,  4'h5, 16, -1, 0, 0,  0, 1'b0};
      vecs[3] = '{1'b0, 4'd5,  5'd3,  4'hF, 3,  -1, 0, 0,  0, 1'b0};
      vecs[4] = '{1'b0, 4'd0,  5'd12, 4'hF, 12, -1, 0, 15, 8, 1'b0};
      vecs[5] = '{1'b0, 4'd15, 5'd17, 4'hA, 16, -1, 0, 0,  0, 1'b0};
      vecs[6] = '{1'b0, 4'd7,  5'd16, 4'hC, 16, -1, 0, 20, 9, 1'b1};
      vecs[7] = '{1'b1, 4'd15, 5'd31, 4'h1, 16, -1, 0, 0,  0, 1'b0};
      vecs[8] = '{1'b0, 4'd3,  5'd1,  4'h6, 1,  -1, 0, 0,  0, 1'b0};
      vecs[9] = '{1'b0, 4'd4,  5'd5,  4'h9, 5,   2, 2, 0,  0, 1'b0};

      slave_reset_n = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b1; cmd_addr = 4'd3; cmd_len = 5'd2; cmd_byteenable = 4'hF;
      wdata_valid = 1'b1; wdata = 32'h1234_5678;
      av_waitrequest = 1'b0; av_readdata = 32'h0; av_readdatavalid = 1'b0; av_endofpacket = 1'b0;
      tick();
      tick();
      check_reset_outputs("init");
      slave_reset_n = 1'b1;
      tick();
      @(negedge slave_clk);
      chk("init_ready_after_release", cmd_ready, 1);
      tick();

      for (int i = 0; i < 10; i++) run_cmd(vecs[i], i);

      // Stray read strobe with nothing in flight
      av_readdatavalid = 1'b1;
      av_readdata = 32'h0000_0BAD;
      @(negedge slave_clk);
      chk("stray_err_before", err_unexpected, 0);
      tick();
      av_readdatavalid = 1'b0;
      @(negedge slave_clk);
      chk("stray_rdata_valid", rdata_valid, 0);
      chk("stray_err_set", err_unexpected, 1);
      err_exp = 1'b1;
      tick();
      run_cmd(vecs[3], 20);

      // Reset while draining two outstanding reads
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd6; cmd_len = 5'd2; cmd_byteenable = 4'hF;
      av_waitrequest = 1'b0; av_readdatavalid = 1'b0;
      @(negedge slave_clk);
      chk("r25_cmd_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      @(negedge slave_clk);
      chk("r25_read0", av_read, 1);
      tick();
      @(negedge slave_clk);
      chk("r25_read1", av_read, 1);
      tick();
      @(negedge slave_clk);
      chk("r25_drain_read", av_read, 0);
      chk("r25_drain_ready", cmd_ready, 0);
      wdata = 32'hFFFF_FFFF;
      wdata_valid = 1'b1;
      slave_reset_n = 1'b0;
      #1;
      check_reset_outputs("r25_async");
      tick();
      tick();
      check_reset_outputs("r25_held");
      slave_reset_n = 1'b1;
      err_exp = 1'b0;
      tick();
      @(negedge slave_clk);
      chk("r25_ready_after_release", cmd_ready, 1);
      chk("r25_err_cleared", err_unexpected, 0);
      tick();
      av_readdatavalid = 1'b1;
      av_readdata = 32'h0000_5A5A;
      tick();
      av_readdatavalid = 1'b0;
      @(negedge slave_clk);
      chk("r25_late_rdata_valid", rdata_valid, 0);
      chk("r25_late_err", err_unexpected, 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
